// File: rtl/id_exe_reg.sv
// ---------------------------------------------------------------------------
// id_exe_reg -- ID/EXE pipeline register for a single-issue integer pipeline.
//
// Captures the decoded instruction leaving the decode stage and presents
// registered operands to the EXE adder. Operand B is either the register-file
// rt value or the extended 16-bit immediate. Each edge resolves with the
// priority flush > stall > load. A bubble is loaded on flush. A 16-bit
// saturating counter tracks every bubble that enters EXE.
//
// Optional feature (macro ID_EXE_FWD_EN):
//   When defined, adds a write-back forwarding port. Matching operands take
//   fwd_data on load. While stalled, the held operands also refresh from
//   fwd_data on a match against the stored rs/rt. Without the macro, stall
//   is a pure hold.
//
// Ports:
//   clk            in   single clock, all state updates on the rising edge
//   rst_n          in   asynchronous active-low reset
//   stall          in   hold current contents
//   flush          in   load a bubble on the next edge (overrides stall)
//   id_valid       in   decode stage presents an instruction
//   id_rs_data     in   [DATA_W]  register-file rs read value
//   id_rt_data     in   [DATA_W]  register-file rt read value
//   id_imm16       in   [16]      instruction immediate field
//   id_rs/rt/rd    in   [RADDR_W] source/destination register numbers
//   id_alu_src     in   1 = operand B is the extended immediate
//   id_imm_zext    in   1 = zero-extend immediate, 0 = sign-extend
//   id_reg_write   in   instruction writes a register
//   fwd_we         in   forwarding write enable        (ID_EXE_FWD_EN only)
//   fwd_dst        in   [RADDR_W] forwarding register  (ID_EXE_FWD_EN only)
//   fwd_data       in   [DATA_W]  forwarding value     (ID_EXE_FWD_EN only)
//   ex_a, ex_b     out  [DATA_W]  registered adder operands
//   ex_dst         out  [RADDR_W] destination register
//   ex_reg_write   out  register write enable for EXE
//   ex_valid       out  EXE holds a real instruction
//   bubble_cnt     out  [16] saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module id_exe_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [15:0]        id_imm16,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_alu_src,
    input  logic               id_imm_zext,
    input  logic               id_reg_write,
`ifdef ID_EXE_FWD_EN
    input  logic               fwd_we,
    input  logic [RADDR_W-1:0] fwd_dst,
    input  logic [DATA_W-1:0]  fwd_data,
`endif
    output logic [DATA_W-1:0]  ex_a,
    output logic [DATA_W-1:0]  ex_b,
    output logic [RADDR_W-1:0] ex_dst,
    output logic               ex_reg_write,
    output logic               ex_valid,
    output logic [15:0]        bubble_cnt
);

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Immediate extension to DATA_W. The sign-extended path goes through a
    // signed cast so the replication of bit 15 is explicit.
    function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm,
                                                  input logic        zext);
        logic signed [15:0]       simm;
        logic signed [DATA_W-1:0] sext;
        logic        [DATA_W-1:0] uext;
        simm = signed'(imm);
        sext = DATA_W'(simm);
        uext = DATA_W'(imm);
        return zext ? uext : sext;
    endfunction

    // Saturating +1 for the bubble counter: sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [RADDR_W-1:0] dst_q, dst_d;
    logic               rw_q, rw_d;
    logic               vld_q, vld_d;
    logic [15:0]        bcnt_q, bcnt_d;
    // Source fields of the held instruction, kept so that forwarding can
    // refresh the held operands while stalled.
    logic [RADDR_W-1:0] rs_q, rs_d;
    logic [RADDR_W-1:0] rt_q, rt_d;
    logic               alu_src_q, alu_src_d;

    // -----------------------------------------------------------------------
    // Decode-side operand selection
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W-1:0]  load_a, load_b;
    logic [DATA_W-1:0]  hold_a, hold_b;
    logic [RADDR_W-1:0] dst_sel;

    always_comb begin
        imm_ext = ext_imm(id_imm16, id_imm_zext);
        // I-type writes rt; R-type writes rd.
        dst_sel = id_alu_src ? id_rt : id_rd;
        load_a  = id_rs_data;
        load_b  = id_alu_src ? imm_ext : id_rt_data;
        hold_a  = a_q;
        hold_b  = b_q;
`ifdef ID_EXE_FWD_EN
        // Register 0 is hard-wired, so a forward targeting it never applies.
        if (fwd_we && (fwd_dst != '0)) begin
            if (id_rs == fwd_dst) begin
                load_a = fwd_data;
            end
            // An immediate operand B never comes from a register.
            if (!id_alu_src && (id_rt == fwd_dst)) begin
                load_b = fwd_data;
            end
            if (rs_q == fwd_dst) begin
                hold_a = fwd_data;
            end
            if (!alu_src_q && (rt_q == fwd_dst)) begin
                hold_b = fwd_data;
            end
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Next-state: flush > stall > load
    // -----------------------------------------------------------------------
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        dst_d     = dst_q;
        rw_d      = rw_q;
        vld_d     = vld_q;
        bcnt_d    = bcnt_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        alu_src_d = alu_src_q;

        if (flush) begin
            // A bubble carries all-zero fields, including the stored
            // sources, so that a held bubble never matches a forward.
            a_d       = '0;
            b_d       = '0;
            dst_d     = '0;
            rw_d      = 1'b0;
            vld_d     = 1'b0;
            rs_d      = '0;
            rt_d      = '0;
            alu_src_d = 1'b0;
            bcnt_d    = sat_inc16(bcnt_q);
        end else if (stall) begin
            a_d = hold_a;
            b_d = hold_b;
        end else begin
            a_d       = load_a;
            b_d       = load_b;
            dst_d     = dst_sel;
            rw_d      = id_reg_write & id_valid & (dst_sel != '0);
            vld_d     = id_valid;
            rs_d      = id_rs;
            rt_d      = id_rt;
            alu_src_d = id_alu_src;
            // An invalid slot entering EXE is also a bubble.
            if (!id_valid) begin
                bcnt_d = sat_inc16(bcnt_q);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Register stage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            dst_q     <= '0;
            rw_q      <= 1'b0;
            vld_q     <= 1'b0;
            bcnt_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            alu_src_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            dst_q     <= dst_d;
            rw_q      <= rw_d;
            vld_q     <= vld_d;
            bcnt_q    <= bcnt_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            alu_src_q <= alu_src_d;
        end
    end

`ifndef ID_EXE_FWD_EN
    // Without forwarding, the held source fields have no consumer. They are
    // gathered here so the plain build carries no dangling state.
    logic unused_hold_fields;
    assign unused_hold_fields = ^{rs_q, rt_q, alu_src_q};
`endif

    assign ex_a         = a_q;
    assign ex_b         = b_q;
    assign ex_dst       = dst_q;
    assign ex_reg_write = rw_q;
    assign ex_valid     = vld_q;
    assign bubble_cnt   = bcnt_q;

endmodule

// File: tb/tb_id_exe_reg.sv
module tb_id_exe_reg;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [15:0] id_imm16;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_alu_src;
    logic        id_imm_zext;
    logic        id_reg_write;
`ifdef ID_EXE_FWD_EN
    logic        fwd_we;
    logic [4:0]  fwd_dst;
    logic [31:0] fwd_data;
`endif
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_dst;
    logic        ex_reg_write;
    logic        ex_valid;
    logic [15:0] bubble_cnt;

    id_exe_reg #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm16     (id_imm16),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_alu_src   (id_alu_src),
        .id_imm_zext  (id_imm_zext),
        .id_reg_write (id_reg_write),
`ifdef ID_EXE_FWD_EN
        .fwd_we       (fwd_we),
        .fwd_dst      (fwd_dst),
        .fwd_data     (fwd_data),
`endif
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_dst       (ex_dst),
        .ex_reg_write (ex_reg_write),
        .ex_valid     (ex_valid),
        .bubble_cnt   (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dst;
        logic        rw;
        logic        v;
        logic [15:0] bc;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] dst, input logic rw, input logic v,
                            input logic [15:0] bc);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.dst = dst; e.rw = rw; e.v = v; e.bc = bc;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_assert++;
        assert (sb.size() > 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".a"},   ex_a,                 e.a);
            chk({e.tag, ".b"},   ex_b,                 e.b);
            chk({e.tag, ".dst"}, {27'd0, ex_dst},      {27'd0, e.dst});
            chk({e.tag, ".rw"},  {31'd0, ex_reg_write}, {31'd0, e.rw});
            chk({e.tag, ".v"},   {31'd0, ex_valid},    {31'd0, e.v});
            chk({e.tag, ".bc"},  {16'd0, bubble_cnt},  {16'd0, e.bc});
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic cyc(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dst, input logic rw, input logic v,
                       input logic [15:0] bc);
        push_exp(tag, a, b, dst, rw, v, bc);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic set_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [15:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic alu_src, input logic zext,
                          input logic rw);
        id_valid = v; id_rs_data = rsd; id_rt_data = rtd; id_imm16 = imm;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_alu_src = alu_src; id_imm_zext = zext; id_reg_write = rw;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(1'b0, 32'd0, 32'd0, 16'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef ID_EXE_FWD_EN
        fwd_we = 1'b0; fwd_dst = 5'd0; fwd_data = 32'd0;
`endif
        // Reset state, before any clock edge
        #3;
        push_exp("reset", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'd0);
        pop_check();

        // Release reset between edges while stalled: bubble stays
        @(posedge clk); #1;
        stall = 1'b1;
        set_id(1'b1, 32'd10, 32'd99, 16'hFFFE, 5'd1, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b1;
        cyc("rst_stall", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'd0);

        // First load on first edge with stall=0: addi with sign-extended -2
        stall = 1'b0;
        cyc("sext", 32'd10, 32'hFFFF_FFFE, 5'd3, 1'b1, 1'b1, 16'd0);
        chk("adder", ex_a + ex_b, 32'd8);

        id_imm_zext = 1'b1;
        cyc("zext", 32'd10, 32'h0000_FFFE, 5'd3, 1'b1, 1'b1, 16'd0);

        set_id(1'b1, 32'd10, 32'd7, 16'hFFFE, 5'd1, 5'd3, 5'd9, 1'b0, 1'b1, 1'b1);
        cyc("rtype", 32'd10, 32'd7, 5'd9, 1'b1, 1'b1, 16'd0);

        id_rd = 5'd0;
        cyc("rd_zero", 32'd10, 32'd7, 5'd0, 1'b0, 1'b1, 16'd0);

        // Invalid slot: loads data, counts a bubble, no write
        set_id(1'b0, 32'd10, 32'd7, 16'hFFFE, 5'd1, 5'd3, 5'd9, 1'b0, 1'b1, 1'b1);
        cyc("invalid", 32'd10, 32'd7, 5'd9, 1'b0, 1'b0, 16'd1);

        set_id(1'b1, 32'h1234, 32'h5678, 16'h0001, 5'd2, 5'd6, 5'd12, 1'b0, 1'b0, 1'b1);
        cyc("load2", 32'h1234, 32'h5678, 5'd12, 1'b1, 1'b1, 16'd1);

        // Stall three edges with changing inputs: nothing moves
        stall = 1'b1;
        set_id(1'b1, 32'hAAAA, 32'hBBBB, 16'h8000, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0, 1'b1);
        cyc("stall1", 32'h1234, 32'h5678, 5'd12, 1'b1, 1'b1, 16'd1);
        set_id(1'b0, 32'hCCCC, 32'hDDDD, 16'h0002, 5'd3, 5'd4, 5'd5, 1'b0, 1'b1, 1'b0);
        cyc("stall2", 32'h1234, 32'h5678, 5'd12, 1'b1, 1'b1, 16'd1);
        set_id(1'b1, 32'hEEEE, 32'hFFFF, 16'h0003, 5'd10, 5'd11, 5'd13, 1'b0, 1'b0, 1'b1);
        cyc("stall3", 32'h1234, 32'h5678, 5'd12, 1'b1, 1'b1, 16'd1);

        // Flush wins over stall
        flush = 1'b1;
        cyc("flush_stall", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'd2);
        stall = 1'b0;
        cyc("flush", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'd3);
        flush = 1'b0;

        // Immediate boundaries
        set_id(1'b1, 32'h0000_000A, 32'd1, 16'h8000, 5'd4, 5'd31, 5'd2, 1'b1, 1'b0, 1'b1);
        cyc("imm_8000", 32'h0000_000A, 32'hFFFF_8000, 5'd31, 1'b1, 1'b1, 16'd3);
        id_imm16 = 16'h7FFF;
        cyc("imm_7fff", 32'h0000_000A, 32'h0000_7FFF, 5'd31, 1'b1, 1'b1, 16'd3);

`ifdef ID_EXE_FWD_EN
        // Forward into A; immediate B ignores a matching rt
        set_id(1'b1, 32'd1, 32'd9, 16'h0010, 5'd4, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1);
        fwd_we = 1'b1; fwd_dst = 5'd4; fwd_data = 32'h55;
        cyc("fwd_a", 32'h55, 32'h10, 5'd4, 1'b1, 1'b1, 16'd3);
        fwd_dst = 5'd0;
        cyc("fwd_r0", 32'd1, 32'h10, 5'd4, 1'b1, 1'b1, 16'd3);
        fwd_we = 1'b0;
        set_id(1'b1, 32'd2, 32'd6, 16'h0000, 5'd2, 5'd4, 5'd7, 1'b0, 1'b0, 1'b1);
        cyc("fwd_ld", 32'd2, 32'd6, 5'd7, 1'b1, 1'b1, 16'd3);
        // Held rt=4 refreshes from forward while stalled
        stall = 1'b1; fwd_we = 1'b1; fwd_dst = 5'd4; fwd_data = 32'h55;
        cyc("fwd_hold", 32'd2, 32'h55, 5'd7, 1'b1, 1'b1, 16'd3);
        flush = 1'b1;
        cyc("fwd_flush", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'd4);
        flush = 1'b0; stall = 1'b0; fwd_we = 1'b0;
        set_id(1'b1, 32'h0000_000A, 32'd1, 16'h7FFF, 5'd4, 5'd31, 5'd2, 1'b1, 1'b0, 1'b1);
        cyc("fwd_reload", 32'h0000_000A, 32'h0000_7FFF, 5'd31, 1'b1, 1'b1, 16'd4);
`endif

        // Asynchronous reset mid-cycle: outputs clear without a clock edge
        #2 rst_n = 1'b0;
        #1;
        push_exp("async_rst", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'd0);
        pop_check();
        @(posedge clk); #1;
        stall = 1'b1;
        #2 rst_n = 1'b1;
        cyc("rst2_stall", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'd0);
        stall = 1'b0;
        set_id(1'b1, 32'd5, 32'd6, 16'h0000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
        cyc("rst2_load", 32'd5, 32'd6, 5'd3, 1'b1, 1'b1, 16'd0);

        // Bubble counter saturation: 65535 flushes reach the ceiling,
        // 65540 in total leave it there
        flush = 1'b1;
        repeat (65534) @(posedge clk);
        cyc("sat_65535", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'hFFFF);
        repeat (4) @(posedge clk);
        cyc("sat_65540", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 16'hFFFF);
        flush = 1'b0;
        set_id(1'b0, 32'd1, 32'd2, 16'h0000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        cyc("sat_invalid", 32'd1, 32'd2, 5'd3, 1'b0, 1'b0, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter RADDR_W, default 5, register-address width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port stall  input  1  hold current contents.
REQ-006 SHALL have port flush  input  1  load bubble on next edge.
REQ-007 SHALL have port id_valid  input  1  decode stage presents an instruction.
REQ-008 SHALL have ports id_rs_data, id_rt_data  input  DATA_W  register-file read values.
REQ-009 SHALL have port id_imm16  input  16  instruction immediate field.
REQ-010 SHALL have ports id_rs, id_rt, id_rd  input  RADDR_W  source/destination register numbers.
REQ-011 SHALL have port id_alu_src  input  1  1 = operand B is the extended immediate (I-type, e.g. addi).
REQ-012 SHALL have port id_imm_zext  input  1  1 = zero-extend immediate, 0 = sign-extend.
REQ-013 SHALL have port id_reg_write  input  1  instruction writes a register.
REQ-014 SHALL have ports ex_a, ex_b  output  DATA_W  registered operands driving the EXE adder a/b.
REQ-015 SHALL have ports ex_dst  output  RADDR_W; ex_reg_write, ex_valid  output  1.
REQ-016 SHALL have port bubble_cnt  output  16  count of bubbles inserted.
REQ-017 SHALL have ports fwd_we  input  1, fwd_dst  input  RADDR_W, fwd_data  input  DATA_W  (present only with ID_EXE_FWD_EN).

Function
REQ-018 SHALL update on rising clk; per-edge priority: flush > stall > load.
REQ-019 Load (stall=0, flush=0) SHALL register ex_a=id_rs_data, ex_b=id_alu_src ? ext(id_imm16) : id_rt_data, one-cycle latency.
REQ-020 ext SHALL replicate bit 15 to DATA_W when id_imm_zext=0, pad zeros when 1 (0xFFFE -> 0xFFFFFFFE / 0x0000FFFE).
REQ-021 ex_dst SHALL be id_rt when id_alu_src=1, else id_rd.
REQ-022 ex_reg_write SHALL be id_reg_write & id_valid & (destination != 0).
REQ-023 ex_valid SHALL equal id_valid on load.
REQ-024 Stall (flush=0) SHALL hold every output unchanged, except operand refresh per REQ-030.
REQ-025 Flush SHALL load a bubble: ex_valid=0, ex_reg_write=0, ex_a=ex_b=0, ex_dst=0, regardless of stall.
REQ-026 bubble_cnt SHALL increment by 1 on every flush edge, and on every load edge with id_valid=0; saturates at 0xFFFF.
REQ-027 Block SHALL internally retain rs, rt and alu_src of the held instruction.

Reset
REQ-028 rst_n=0 SHALL immediately clear ex_a, ex_b, ex_dst, ex_reg_write, ex_valid, bubble_cnt and internal fields to 0, independent of clk.
REQ-029 Reset deassertion mid-stall SHALL leave a bubble; first load occurs on first edge with stall=0.

Configuration
REQ-030 With ID_EXE_FWD_EN defined: fwd_* ports exist; when fwd_we=1 and fwd_dst!=0, on load ex_a takes fwd_data if id_rs==fwd_dst and ex_b takes fwd_data if id_alu_src=0 and id_rt==fwd_dst; while stalled, held ex_a/ex_b likewise refresh from fwd_data on a match with stored rs/rt; flush overrides.
REQ-031 Without ID_EXE_FWD_EN: fwd_* ports absent, no forwarding, stall is a pure hold.

Verification
REQ-032 Load id_rs_data=10, id_imm16=0xFFFE, alu_src=1, zext=0, id_rt=3, reg_write=1, valid=1 -> next edge ex_a=10, ex_b=0xFFFFFFFE, ex_dst=3, ex_reg_write=1 (adder result 8).
REQ-033 Same with zext=1 -> ex_b=0x0000FFFE; alu_src=0, id_rt_data=7, id_rd=9 -> ex_b=7, ex_dst=9; id_rd=0 -> ex_reg_write=0.
REQ-034 Stall=1 for 3 edges while inputs change -> outputs constant; flush=1 with stall=1 -> bubble, bubble_cnt +1.
REQ-035 (FWD_EN) id_rs=4, fwd_we=1, fwd_dst=4, fwd_data=0x55 -> ex_a=0x55; fwd_dst=0 -> ex_a=id_rs_data; stalled held rt=4 match -> ex_b refreshes to 0x55.
REQ-036 rst_n low between clock edges mid-operation -> all outputs 0 immediately; 65540 consecutive flushes -> bubble_cnt=0xFFFF.
